// File: rtl/axi_lite_fifo_v2.sv
// AXI4-Lite slave exposing a FIFO through DATA/STATUS/CTRL/IRQ word registers.
// Optional level interrupt output enabled with `define AXI_LITE_FIFO_V2_IRQ_EN.
module axi_lite_fifo_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
`ifdef AXI_LITE_FIFO_V2_IRQ_EN
  ,
  output logic                          irq
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic                       awready_r, bvalid_r, arready_r, rvalid_r;
  logic [1:0]                 bresp_r, rresp_r;
  logic [31:0]                rdata_r;
  logic [FIFO_DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]              count_r;
  logic                       ovf_r, udf_r, pend_r;
  logic [7:0]                 thr_r;
`ifdef AXI_LITE_FIFO_V2_IRQ_EN
  logic                       irq_en_r;
  logic                       irq_r;
`endif

  logic                       wr_hs_s, rd_hs_s, ctrl_wr_s, flush_s, clr_flags_s, clr_pend_s;
  logic                       push_req_s, pop_req_s, push_ok_s, pop_ok_s, ovf_set_s, udf_set_s;
  logic                       irq_en_s, pend_next_s;
  logic [CW-1:0]              count_next_s;
  logic [8:0]                 cnt9_s;
  logic [31:0]                head_s, status_s, ctrl_s, rd_word_s;
  logic [1:0]                 rd_resp_s;
  logic                       unused_s;

  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WDATA};

  // Decode, FIFO update arithmetic and read-data mux
  always_comb begin
    wr_hs_s     = awready_r & S_AXI_AWVALID & S_AXI_WVALID;
    rd_hs_s     = arready_r & S_AXI_ARVALID;
    ctrl_wr_s   = wr_hs_s & (S_AXI_AWADDR[3:2] == 2'd2);
    flush_s     = ctrl_wr_s & S_AXI_WDATA[0];
    clr_flags_s = ctrl_wr_s & S_AXI_WDATA[1];
    clr_pend_s  = wr_hs_s & (S_AXI_AWADDR[3:2] == 2'd3) & S_AXI_WDATA[0];
    push_req_s  = wr_hs_s & (S_AXI_AWADDR[3:2] == 2'd0);
    pop_req_s   = rd_hs_s & (S_AXI_ARADDR[3:2] == 2'd0);
    // A flush in the same cycle wins: the pop underflows and the push is dropped quietly.
    pop_ok_s    = pop_req_s & (count_r != {CW{1'b0}}) & !flush_s;
    push_ok_s   = push_req_s & !flush_s & ((count_r < DEPTH_C) | pop_ok_s);
    ovf_set_s   = push_req_s & !flush_s & !push_ok_s;
    udf_set_s   = pop_req_s & !pop_ok_s;
    if (flush_s) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + CW'(push_ok_s) - CW'(pop_ok_s);
    end
    cnt9_s      = 9'(count_r);
    pend_next_s = ((thr_r != 8'd0) && (cnt9_s >= {1'b0, thr_r})) | (pend_r & !clr_pend_s);
`ifdef AXI_LITE_FIFO_V2_IRQ_EN
    irq_en_s    = irq_en_r;
`else
    irq_en_s    = 1'b0;
`endif
    head_s                      = 32'd0;
    head_s[FIFO_DATA_WIDTH-1:0] = mem_r[rd_ptr_r];
    status_s                    = 32'd0;
    status_s[0]                 = (count_r == {CW{1'b0}});
    status_s[1]                 = (count_r == DEPTH_C);
    status_s[2]                 = ovf_r;
    status_s[3]                 = udf_r;
    status_s[8 +: CW]           = count_r;
    ctrl_s                      = 32'd0;
    ctrl_s[2]                   = irq_en_s;
    ctrl_s[15:8]                = thr_r;
    rd_word_s                   = 32'd0;
    rd_resp_s                   = 2'b00;
    case (S_AXI_ARADDR[3:2])
      2'd0: begin
        if (pop_ok_s) begin
          rd_word_s = head_s;
        end else begin
          rd_word_s = 32'd0;
          rd_resp_s = 2'b10;
        end
      end
      2'd1:    rd_word_s = status_s;
      2'd2:    rd_word_s = ctrl_s;
      2'd3:    rd_word_s = {31'd0, pend_r};
      default: rd_word_s = 32'd0;
    endcase
  end

  // AXI handshake and response registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      awready_r <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= 32'd0;
    end else begin
      awready_r <= !awready_r && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_r;
      arready_r <= !arready_r && S_AXI_ARVALID && !rvalid_r;
      if (wr_hs_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= ovf_set_s ? 2'b10 : 2'b00;
      end else if (bvalid_r && S_AXI_BREADY) begin
        bvalid_r <= 1'b0;
      end
      if (rd_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_word_s;
        rresp_r  <= rd_resp_s;
      end else if (rvalid_r && S_AXI_RREADY) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // FIFO pointers, occupancy, sticky flags and control registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
      udf_r    <= 1'b0;
      pend_r   <= 1'b0;
      thr_r    <= 8'(FIFO_DEPTH / 2);
`ifdef AXI_LITE_FIFO_V2_IRQ_EN
      irq_en_r <= 1'b0;
      irq_r    <= 1'b0;
`endif
    end else begin
      count_r <= count_next_s;
      pend_r  <= pend_next_s;
      if (flush_s) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        wr_ptr_r <= wr_ptr_r + PW'(push_ok_s);
        rd_ptr_r <= rd_ptr_r + PW'(pop_ok_s);
      end
      ovf_r <= (ovf_r & !clr_flags_s) | ovf_set_s;
      udf_r <= (udf_r & !clr_flags_s) | udf_set_s;
      if (ctrl_wr_s) begin
        thr_r <= S_AXI_WDATA[15:8];
      end
`ifdef AXI_LITE_FIFO_V2_IRQ_EN
      if (ctrl_wr_s) begin
        irq_en_r <= S_AXI_WDATA[2];
      end
      irq_r <= pend_next_s & irq_en_r;
`endif
    end
  end

  // Storage array: no reset needed, contents are only visible through count
  always_ff @(posedge ACLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= S_AXI_WDATA[FIFO_DATA_WIDTH-1:0];
    end
  end

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = awready_r;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
`ifdef AXI_LITE_FIFO_V2_IRQ_EN
  assign irq = irq_r;
`endif

endmodule
